// File: rtl/sparc_decode.sv
// sparc_decode: decode stage of the Sparcy SPARC V8 pipeline.
// Takes fetched words over valid/ready, splits out the format fields, forms the
// immediate and presents one registered bundle (plus rf read addresses) to execute.
// Optional feature: define SPARCY_DECODE_SCOREBOARD_EN to add the per-register busy
// scoreboard that stalls read-after-write hazards until writeback.
module sparc_decode #(
  parameter int INST_SIZE     = 32,
  parameter int REG_BITS_SIZE = 5,
  parameter int NO_OF_REG     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [INST_SIZE-1:0]     if_inst,
  input  logic [INST_SIZE-1:0]     if_pc,
  output logic                     if_ready,
  input  logic                     flush,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INST_SIZE-1:0]     id_pc,
  output logic [1:0]               id_op,
  output logic [5:0]               id_op3,
  output logic [REG_BITS_SIZE-1:0] id_rd,
  output logic [REG_BITS_SIZE-1:0] rf_rs1,
  output logic [REG_BITS_SIZE-1:0] rf_rs2,
  output logic [INST_SIZE-1:0]     id_imm,
  output logic                     id_use_imm,
  output logic                     id_writes_rd,
  output logic                     id_illegal,
  input  logic                     wb_valid,
  input  logic [REG_BITS_SIZE-1:0] wb_rd
);

  typedef struct packed {
    logic [INST_SIZE-1:0]     pc;
    logic [1:0]               op;
    logic [5:0]               op3;
    logic [REG_BITS_SIZE-1:0] rd;
    logic [REG_BITS_SIZE-1:0] rs1;
    logic [REG_BITS_SIZE-1:0] rs2;
    logic [INST_SIZE-1:0]     imm;
    logic                     use_imm;
    logic                     writes_rd;
    logic                     illegal;
  } bundle_t;

  // simm13 of the arithmetic/memory formats, sign-extended to a full word
  function automatic logic signed [INST_SIZE-1:0] sext_simm13(input logic [12:0] f);
    return {{(INST_SIZE-13){f[12]}}, f};
  endfunction

  // Bicc word displacement: sign-extend disp22, then scale to a byte offset
  function automatic logic signed [INST_SIZE-1:0] sext_disp22_x4(input logic [21:0] f);
    return {{(INST_SIZE-24){f[21]}}, f, 2'b00};
  endfunction

  bundle_t dec;
  logic    dec_rd_read;     // store: rd supplies the store data, so it is a source
  bundle_t bundle_q, bundle_d;
  logic    id_valid_q, id_valid_d;
  logic    hazard;
  logic    fire;

  // Field extraction and immediate formation for the word fetch is presenting
  always_comb begin
    dec         = '0;
    dec_rd_read = 1'b0;
    dec.pc      = if_pc;
    dec.op      = if_inst[31:30];
    dec.rd      = REG_BITS_SIZE'(if_inst[29:25]);
    case (if_inst[31:30])
      2'b01: begin
        dec.rd        = REG_BITS_SIZE'(15);
        dec.writes_rd = 1'b1;
        dec.imm       = INST_SIZE'({if_inst[29:0], 2'b00});
        dec.use_imm   = 1'b1;
      end
      2'b00: begin
        dec.op3 = {3'b000, if_inst[24:22]};
        case (if_inst[24:22])
          3'b100: begin
            dec.imm       = INST_SIZE'({if_inst[21:0], 10'b0});
            dec.use_imm   = 1'b1;
            dec.writes_rd = (if_inst[29:25] != 5'd0);
          end
          3'b010: begin
            dec.imm = sext_disp22_x4(if_inst[21:0]);
          end
          default: begin
            dec.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec.op3 = if_inst[24:19];
        dec.rs1 = REG_BITS_SIZE'(if_inst[18:14]);
        if (if_inst[13]) begin
          dec.imm     = sext_simm13(if_inst[12:0]);
          dec.use_imm = 1'b1;
        end else begin
          dec.rs2 = REG_BITS_SIZE'(if_inst[4:0]);
        end
        if (if_inst[31:30] == 2'b11 && if_inst[21]) begin
          dec_rd_read = 1'b1;
        end else begin
          dec.writes_rd = (if_inst[29:25] != 5'd0);
        end
      end
    endcase
  end

`ifdef SPARCY_DECODE_SCOREBOARD_EN
  logic [NO_OF_REG-1:0] busy_q, busy_d;

  // rs2 is zero for immediate forms and r0 is never busy, so it can be tested unconditionally
  assign hazard = if_valid &&
                  (busy_q[dec.rs1] || busy_q[dec.rs2] || (dec_rd_read && busy_q[dec.rd]));

  // Busy update: writeback and flush clear, accepted writers set (set wins on a tie)
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (flush && id_valid_q && bundle_q.writes_rd) begin
      busy_d[bundle_q.rd] = 1'b0;
    end
    if (fire && dec.writes_rd) begin
      busy_d[dec.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = wb_valid ^ (^wb_rd) ^ dec_rd_read ^ (NO_OF_REG == 0);
  assign hazard    = 1'b0;
`endif

  assign if_ready = !flush && (!id_valid_q || id_ready) && !hazard;
  assign fire     = if_valid && if_ready;

  // Output register: load on accept, hold otherwise; flush beats the consume handshake
  always_comb begin
    bundle_d   = bundle_q;
    id_valid_d = id_valid_q;
    if (fire) begin
      bundle_d = dec;
    end
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (fire) begin
      id_valid_d = 1'b1;
    end else if (id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  // Decoded bundle and valid flops
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      bundle_q   <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      bundle_q   <= bundle_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_pc        = bundle_q.pc;
  assign id_op        = bundle_q.op;
  assign id_op3       = bundle_q.op3;
  assign id_rd        = bundle_q.rd;
  assign rf_rs1       = bundle_q.rs1;
  assign rf_rs2       = bundle_q.rs2;
  assign id_imm       = bundle_q.imm;
  assign id_use_imm   = bundle_q.use_imm;
  assign id_writes_rd = bundle_q.writes_rd;
  assign id_illegal   = bundle_q.illegal;

endmodule

// File: doc/sparc_decode.md
# sparc_decode

Instruction decode stage for the Sparcy SPARC V8 pipeline. It accepts fetched instruction words over a valid/ready handshake, extracts the format fields, and forms the immediate operand. It drives the register-file read addresses and presents a registered decoded bundle to execute. An optional per-register scoreboard interlocks read-after-write hazards until writeback.

## Interface
- INST_SIZE, 32, instruction and data word width
- REG_BITS_SIZE, 5, register specifier width
- NO_OF_REG, 32, architectural registers tracked by the scoreboard
---
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_inst  in  INST_SIZE  instruction word
- if_pc  in  INST_SIZE  PC of if_inst
- if_ready  out  1  decode accepts this cycle
- flush  in  1  kill the held instruction (branch redirect)
- id_valid  out  1  decoded bundle valid
- id_ready  in  1  execute consumes the bundle
- id_pc  out  INST_SIZE  registered PC
- id_op  out  2  inst[31:30]
- id_op3  out  6  inst[24:19] for op=1x; {3'b0, op2} for op=00; 0 for call
- id_rd  out  REG_BITS_SIZE  destination (15 for call)
- rf_rs1, rf_rs2  out  REG_BITS_SIZE  register-file read addresses, registered, equal to the bundle's rs1/rs2
- id_imm  out  INST_SIZE  formed immediate
- id_use_imm  out  1  operand 2 is id_imm
- id_writes_rd  out  1  instruction writes a nonzero rd
- id_illegal  out  1  unsupported encoding
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  REG_BITS_SIZE  register written back

## Operation
- Fire: if_valid && if_ready. On fire, the decoded fields load into the output register and id_valid=1.
- if_ready = !flush && (!id_valid || id_ready) && !hazard.
- id_valid clears when id_ready && !fire.
- Decode by op:
  - op=01 call: rd=15, writes=1, imm={inst[29:0],2'b00}, use_imm=1.
  - op=00, op2=100 sethi: imm={inst[21:0],10'b0}, use_imm=1, writes=(rd!=0).
  - op=00, op2=010 Bicc: imm=sext(inst[21:0])<<2, writes=0.
  - op=00, other op2: illegal=1, writes=0.
  - op=10/11: rs1=inst[18:14].
    - i=inst[13]=1: imm=sext(inst[12:0]), use_imm=1, rs2=0.
    - i=0: rs2=inst[4:0], imm=0.
- Write rules:
  - op=10: writes=(rd!=0).
  - op=11 load (op3[2]=0): writes=(rd!=0).
  - op=11 store (op3[2]=1): writes=0; rd is read as store data.
- r0 is never marked busy.
- Outputs hold stable while id_valid && !id_ready.

## Timing
- Reset: id_valid=0; all id_* and rf_* outputs 0; scoreboard clear; if_ready=1 next cycle when flush=0.
- Latency: fire at cycle N gives id_valid, rf_rs1 and rf_rs2 valid at cycle N+1. The register file returns read data in that same cycle.
- Back-to-back: one instruction per cycle when id_ready=1 continuously.
- Flush:
  - Clears id_valid next cycle.
  - Clears the busy bit set by the killed bundle.
  - Blocks acceptance in the flush cycle.
  - Flush takes priority over an id_ready handshake in the same cycle.
- Reset mid-operation discards the held bundle and clears all busy bits.

## Configuration
- SPARCY_DECODE_SCOREBOARD_EN defined:
  - A NO_OF_REG-bit busy vector is maintained.
  - Fire with writes=1 sets busy[rd].
  - wb_valid clears busy[wb_rd].
  - A same-cycle set and clear on the same register leaves it set.
  - hazard=1 when if_valid and any source register is busy. Sources are rs1, rs2 when i=0, and rd for stores.
  - A clear is visible to hazard the cycle after wb_valid; there is no same-cycle bypass.
- Macro not defined: no busy vector; hazard=0; wb_valid and wb_rd are ignored. Software or forwarding resolves dependencies.

## Test plan
- 0x86004002 (add %r1,%r2,%r3) with id_ready=1 -> next cycle id_valid=1, id_op=2, id_op3=0, rf_rs1=1, rf_rs2=2, id_rd=3, use_imm=0, writes=1.
- 0x09012345 (sethi 0x12345,%r4) -> id_imm=0x048D1400, id_rd=4, use_imm=1, writes=1. Encoding 0x01000000 (nop) -> writes=0, illegal=0.
- 0x8C017FFF (add %r5,-1,%r6) -> id_imm=0xFFFFFFFF, rf_rs1=5, use_imm=1, id_rd=6.
- Scoreboard build:
  - Fire 0x86004002, then present add %r3,%r2,%r7 -> if_ready=0.
  - Pulse wb_valid with wb_rd=3 -> if_ready=1 the following cycle; the second instruction fires.
- Hold id_ready=0 for 3 cycles with the bundle held and if_valid=1 -> if_ready=0 and id_* stable. Raise id_ready -> the next instruction loads in the same cycle.
- Flush with the held add %r3 (scoreboard build) -> id_valid=0 next cycle; busy[3] cleared. A reader of %r3 presented next fires without a stall.
